// File: rtl/mult_issue_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller: FSM encoding,
// datapath widths and a small operand helper.
package mult_issue_ctrl_pkg;

    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // A pair with either operand zero has a zero product and skips the core.
    function automatic logic is_zero_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        return (a == {OP_W{1'b0}}) || (b == {OP_W{1'b0}});
    endfunction

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Bundle of the operand port, the multiplier-core pins and the result port.
// slave is the controller's view, master is the view of its surroundings.
interface mult_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    import mult_issue_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_mlier;
    logic [OP_W-1:0]   in_mcand;
    logic [TAG_W-1:0]  in_tag;

    logic              mul_start;
    logic [OP_W-1:0]   mul_mlier;
    logic [OP_W-1:0]   mul_mcand;
    logic [PROD_W-1:0] mul_prodt;
    logic              mul_valid;

    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_prodt;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    logic              busy;

    modport slave (
        input  in_valid, in_mlier, in_mcand, in_tag,
        input  mul_prodt, mul_valid,
        input  out_ready,
        output in_ready,
        output mul_start, mul_mlier, mul_mcand,
        output out_valid, out_prodt, out_tag, out_err,
        output busy
    );

    modport master (
        output in_valid, in_mlier, in_mcand, in_tag,
        output mul_prodt, mul_valid,
        output out_ready,
        input  in_ready,
        input  mul_start, mul_mlier, mul_mcand,
        input  out_valid, out_prodt, out_tag, out_err,
        input  busy
    );

endinterface

// File: rtl/mult_issue_ctrl_op_fifo.sv
// Operand FIFO: synchronous, first-word-fall-through head, power-of-two depth.
// Occupancy is tracked with a counter that can express 0..DEPTH.
module mult_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == {CW{1'b0}});
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= {AW{1'b0}};
            rptr  <= {AW{1'b0}};
            count <= {CW{1'b0}};
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; entries are only read once written, so no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue controller for the 32x32 signed shift-add multiplier. Operand pairs
// are queued, zero pairs are answered directly, others are driven into the
// core with start held for the whole operation, and a stuck core is cut off
// after TIMEOUT RUN cycles with an error result.
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    mult_issue_ctrl_if.slave bus
);

    localparam int FW    = 2 * OP_W + TAG_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    logic [TAG_W-1:0]  head_tag;
    logic [OP_W-1:0]   head_mlier;
    logic [OP_W-1:0]   head_mcand;
    logic              head_zero;

    logic [OP_W-1:0]   op_mlier;
    logic [OP_W-1:0]   op_mcand;
    logic [TAG_W-1:0]  op_tag;
    logic [CNT_W-1:0]  cnt;

    logic              res_valid;
    logic [PROD_W-1:0] res_prodt;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;

    logic              slot_free;
    logic              timeout_hit;
    logic              mul_start_s;
    logic              op_load;
    logic              res_we;
    logic [PROD_W-1:0] res_prodt_d;
    logic [TAG_W-1:0]  res_tag_d;
    logic              res_err_d;

    assign fifo_wdata = {bus.in_tag, bus.in_mlier, bus.in_mcand};
    assign fifo_push  = bus.in_valid & ~fifo_full;
    assign {head_tag, head_mlier, head_mcand} = fifo_rdata;

    mult_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_zero   = is_zero_pair(head_mlier, head_mcand);
    assign slot_free   = ~res_valid | bus.out_ready;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && slot_free && !head_zero) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.mul_valid) begin
                    state_next = ST_CAPTURE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_CAPTURE: begin
                if (slot_free) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_CAPTURE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-state strobes: core start, FIFO pop, operand load and result write.
    always_comb begin
        mul_start_s = 1'b0;
        fifo_pop    = 1'b0;
        op_load     = 1'b0;
        res_we      = 1'b0;
        res_prodt_d = {PROD_W{1'b0}};
        res_tag_d   = op_tag;
        res_err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop = 1'b1;
                    if (head_zero) begin
                        res_we    = 1'b1;
                        res_tag_d = head_tag;
                    end else begin
                        op_load = 1'b1;
                    end
                end else begin
                    fifo_pop = 1'b0;
                end
            end
            ST_RUN: begin
                mul_start_s = 1'b1;
                if (!bus.mul_valid && timeout_hit) begin
                    res_we    = 1'b1;
                    res_err_d = 1'b1;
                end else begin
                    res_we = 1'b0;
                end
            end
            ST_CAPTURE: begin
                // The core presents its product one cycle after mul_valid, so
                // start stays high here until the product has been taken.
                mul_start_s = 1'b1;
                if (slot_free) begin
                    res_we      = 1'b1;
                    res_prodt_d = bus.mul_prodt;
                end else begin
                    res_we = 1'b0;
                end
            end
            default: begin
                mul_start_s = 1'b0;
            end
        endcase
    end

    // Operand registers feeding the core, stable for the whole operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_mlier <= {OP_W{1'b0}};
            op_mcand <= {OP_W{1'b0}};
            op_tag   <= {TAG_W{1'b0}};
        end else if (op_load) begin
            op_mlier <= head_mlier;
            op_mcand <= head_mcand;
            op_tag   <= head_tag;
        end
    end

    // RUN-cycle counter used for the hung-core timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= {CNT_W{1'b0}};
        end else if (op_load) begin
            cnt <= {CNT_W{1'b0}};
        end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Result register; a same-cycle write takes precedence over acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_prodt <= {PROD_W{1'b0}};
            res_tag   <= {TAG_W{1'b0}};
            res_err   <= 1'b0;
        end else if (res_we) begin
            res_valid <= 1'b1;
            res_prodt <= res_prodt_d;
            res_tag   <= res_tag_d;
            res_err   <= res_err_d;
        end else if (res_valid && bus.out_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = ~fifo_full;
    assign bus.mul_start = mul_start_s;
    assign bus.mul_mlier = op_mlier;
    assign bus.mul_mcand = op_mcand;
    assign bus.out_valid = res_valid;
    assign bus.out_prodt = res_prodt;
    assign bus.out_tag   = res_tag;
    assign bus.out_err   = res_err;
    assign bus.busy      = (state != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural hold-start multiplier
// and a queue of expected results built from the accepted operand pairs.
module tb_mult_issue_ctrl;
    import mult_issue_ctrl_pkg::*;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 40;
    localparam int LAT     = 12;

    typedef struct packed {
        logic [63:0]      prodt;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mult_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mult_issue_ctrl #(
        .DEPTH   (4),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    res_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          run_cycles = 0;
    logic        start_seen = 1'b0;
    logic        hang = 1'b0;
    int          mcnt;
    logic        mdone;
    logic [63:0] hold_p;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // Multiplier model: valid after LAT start cycles, product one cycle later.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mcnt <= 0;
            mdone <= 1'b0;
            bus.mul_valid <= 1'b0;
            bus.mul_prodt <= 64'd0;
        end else if (!bus.mul_start) begin
            mcnt <= 0;
            mdone <= 1'b0;
            bus.mul_valid <= 1'b0;
            bus.mul_prodt <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (hang) begin
            bus.mul_valid <= 1'b0;
        end else if (mdone) begin
            bus.mul_valid <= 1'b0;
            if (bus.mul_valid) bus.mul_prodt <= smul(bus.mul_mlier, bus.mul_mcand);
        end else if (mcnt == LAT - 1) begin
            bus.mul_valid <= 1'b1;
            mdone <= 1'b1;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One clock: bookkeeping at the falling edge, return 1 time unit after rise.
    task automatic tick();
        res_t e;
        logic z;
        @(negedge clock);
        if (bus.mul_start) begin
            run_cycles++;
            start_seen = 1'b1;
        end
        if (bus.in_valid && bus.in_ready) begin
            z = (bus.in_mlier == 32'd0) || (bus.in_mcand == 32'd0);
            e.tag = bus.in_tag;
            e.err = hang && !z;
            e.prodt = (z || e.err) ? 64'd0 : smul(bus.in_mlier, bus.in_mcand);
            exp_q.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_result: observed tag %h expected no result", bus.out_tag);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_prodt", bus.out_prodt, e.prodt);
                check("sb_tag", 64'(bus.out_tag), 64'(e.tag));
                check("sb_err", 64'(bus.out_err), 64'(e.err));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_op(input logic [31:0] m, input logic [31:0] c, input logic [TAG_W-1:0] t);
        logic done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mlier = m;
        bus.in_mcand = c;
        bus.in_tag   = t;
        for (int i = 0; i < 200 && !done; i++) begin
            done = bus.in_ready;
            tick();
        end
        tests++;
        assert (done) else begin
            fails++;
            $error("FAIL push_wait: observed in_ready low expected accept of tag %0d", t);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        for (int i = 0; i < 300 && !bus.out_valid; i++) tick();
        tests++;
        assert (bus.out_valid) else begin
            fails++;
            $error("FAIL %s: observed no out_valid expected a result within budget", name);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && (exp_q.size() != 0 || bus.out_valid || bus.busy); i++) tick();
        tests++;
        assert (exp_q.size() == 0 && !bus.busy) else begin
            fails++;
            $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mlier = 32'd0;
        bus.in_mcand = 32'd0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mul_start", 64'(bus.mul_start), 64'd0);
        check("rst_mul_mlier", 64'(bus.mul_mlier), 64'd0);
        check("rst_out_prodt", bus.out_prodt, 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_out_err", 64'(bus.out_err), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        #8;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 3 * 5
        push_op(32'd3, 32'd5, 4'd1);
        wait_result("res_3x5");
        check("p_3x5", bus.out_prodt, 64'd15);
        check("start_low_after", 64'(bus.mul_start), 64'd0);
        tick();

        // -7 * 6
        push_op(32'hFFFF_FFF9, 32'd6, 4'd2);
        wait_result("res_m7x6");
        check("p_m7x6", bus.out_prodt, 64'hFFFF_FFFF_FFFF_FFD6);
        tick();
        wait_drain();

        // zero bypass: 0 * 0x12345678
        start_seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mlier = 32'd0;
        bus.in_mcand = 32'h1234_5678;
        bus.in_tag = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        check("zero_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        check("zero_valid_2cyc", 64'(bus.out_valid), 64'd1);
        check("zero_prodt", bus.out_prodt, 64'd0);
        tick();
        check("zero_no_start", 64'(start_seen), 64'd0);
        wait_drain();

        // backpressure: five back-to-back pushes with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_op($urandom | 32'd1, $urandom | 32'd1, 4'(4 + i));
        end
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        wait_result("bp_first");
        hold_p = bus.out_prodt;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_prodt", bus.out_prodt, hold_p);
            check("bp_hold_tag", 64'(bus.out_tag), 64'd4);
        end
        bus.out_ready = 1'b1;
        wait_drain();

        // timeout against a core that never answers
        hang = 1'b1;
        run_cycles = 0;
        push_op(32'd2, 32'd2, 4'd9);
        wait_result("res_timeout");
        check("to_err", 64'(bus.out_err), 64'd1);
        check("to_prodt", bus.out_prodt, 64'd0);
        check("to_run_cycles", 64'(run_cycles), 64'(TIMEOUT));
        tick();
        hang = 1'b0;
        push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10);
        wait_result("res_after_to");
        check("after_to_prodt", bus.out_prodt, 64'd1);
        wait_drain();

        // asynchronous reset in the middle of RUN
        run_cycles = 0;
        push_op(32'h0000_1234, 32'h0000_5678, 4'd11);
        push_op(32'd7, 32'd9, 4'd12);
        push_op(32'd8, 32'd9, 4'd13);
        for (int i = 0; i < 20 && run_cycles < 4; i++) tick();
        check("mid_run_start", 64'(bus.mul_start), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_mul_start", 64'(bus.mul_start), 64'd0);
        check("ar_out_valid", 64'(bus.out_valid), 64'd0);
        check("ar_in_ready", 64'(bus.in_ready), 64'd1);
        check("ar_busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        push_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd14);
        wait_result("res_max");
        check("p_max", bus.out_prodt, 64'h3FFF_FFFF_0000_0001);
        check("tag_max", 64'(bus.out_tag), 64'd14);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
